// File: rtl/arith_pkg.sv
// Shared types and sizing helpers for the arithmetic unit's sequential blocks.
package arith_pkg;

    localparam int N_DEF = 32;

    // Width of an iteration counter that must hold the value n/2.
    function automatic int cnt_width(input int n);
        return $clog2(n / 2 + 1);
    endfunction

    localparam int CNT_W = cnt_width(N_DEF);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    typedef logic [1:0] digit_t;

endpackage

// File: rtl/radix4_divider_if.sv
// Start/busy/done handshake and operand/result bus of the radix-4 divider.
interface radix4_divider_if #(parameter int N = 32);
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/radix4_divider_qsel.sv
// Radix-4 restoring digit selection: picks the largest multiple of D not above T.
module radix4_qsel
    import arith_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic [N+1:0] t,
    input  logic [N-1:0] d,
    output digit_t       q,
    output logic [N+1:0] p_next
);
    logic [N+1:0] d1, d2, d3;
    logic [N+2:0] s1, s2, s3;

    // Subtract each multiple with one extra bit; the top bit is the borrow (T < kD).
    always_comb begin
        d1     = {2'b00, d};
        d2     = d1 << 1;
        d3     = d1 + d2;
        s1     = {1'b0, t} - {1'b0, d1};
        s2     = {1'b0, t} - {1'b0, d2};
        s3     = {1'b0, t} - {1'b0, d3};
        q      = 2'd0;
        p_next = t;
        if (!s3[N+2]) begin
            q      = 2'd3;
            p_next = s3[N+1:0];
        end else if (!s2[N+2]) begin
            q      = 2'd2;
            p_next = s2[N+1:0];
        end else if (!s1[N+2]) begin
            q      = 2'd1;
            p_next = s1[N+1:0];
        end
    end
endmodule

// File: rtl/radix4_divider.sv
// Signed sequential divider, 2 quotient bits per clock on unsigned magnitudes.
//   state | meaning
//   IDLE  | waiting for start; last results held on the outputs
//   CALC  | N/2 radix-4 iterations on |dividend| / |divisor|
//   FIX   | apply signs and the divide-by-zero / overflow cases
//   DONE  | raise done for one cycle, drop busy
module radix4_divider
    import arith_pkg::*;
#(
    parameter int N = N_DEF
) (
    input logic            clk,
    input logic            rst,
    radix4_divider_if.slave bus
);
    localparam int            CW    = cnt_width(N);
    localparam logic [CW-1:0] ITERS = CW'(N / 2);
    localparam logic [N-1:0]  MIN_NEG = {1'b1, {(N-1){1'b0}}};

    div_state_t    state;
    logic [CW-1:0] cnt;
    logic [N+1:0]  p;
    logic [N-1:0]  q_acc;
    logic [N-1:0]  d_mag;
    logic [N-1:0]  dvd_orig;
    logic          sign_q, sign_r, d_zero, ovf;

    logic [N-1:0]  dvd_mag, dvs_mag;
    logic [N+1:0]  t, p_next;
    digit_t        dig;

    assign dvd_mag = bus.dividend[N-1] ? -bus.dividend : bus.dividend;
    assign dvs_mag = bus.divisor[N-1]  ? -bus.divisor  : bus.divisor;
    assign t       = (p << 2) | {{N{1'b0}}, q_acc[N-1:N-2]};

    radix4_qsel #(.N(N)) u_qsel (
        .t      (t),
        .d      (d_mag),
        .q      (dig),
        .p_next (p_next)
    );

    // Sequencing FSM with registered handshake and result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            cnt             <= '0;
            p               <= '0;
            q_acc           <= '0;
            d_mag           <= '0;
            dvd_orig        <= '0;
            sign_q          <= 1'b0;
            sign_r          <= 1'b0;
            d_zero          <= 1'b0;
            ovf             <= 1'b0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.quotient    <= '0;
            bus.remainder   <= '0;
            bus.div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        d_mag    <= dvs_mag;
                        q_acc    <= dvd_mag;
                        p        <= '0;
                        dvd_orig <= bus.dividend;
                        sign_q   <= bus.dividend[N-1] ^ bus.divisor[N-1];
                        sign_r   <= bus.dividend[N-1];
                        d_zero   <= (bus.divisor == '0);
                        ovf      <= (bus.dividend == MIN_NEG) && (bus.divisor == '1);
                        cnt      <= ITERS;
                        bus.busy <= 1'b1;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    p     <= p_next;
                    q_acc <= {q_acc[N-3:0], dig};
                    cnt   <= cnt - 1'b1;
                    if (cnt == CW'(1)) state <= FIX;
                end
                FIX: begin
                    if (d_zero) begin
                        bus.quotient    <= '1;
                        bus.remainder   <= dvd_orig;
                        bus.div_by_zero <= 1'b1;
                    end else if (ovf) begin
                        bus.quotient    <= MIN_NEG;
                        bus.remainder   <= '0;
                        bus.div_by_zero <= 1'b0;
                    end else begin
                        bus.quotient    <= sign_q ? -q_acc : q_acc;
                        bus.remainder   <= sign_r ? -p[N-1:0] : p[N-1:0];
                        bus.div_by_zero <= 1'b0;
                    end
                    state <= DONE;
                end
                DONE: begin
                    bus.done <= 1'b1;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_radix4_divider.sv
// Directed + random checks of radix4_divider against a scoreboard of C-style division results.
module tb_radix4_divider;
    typedef struct packed {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    radix4_divider_if #(.N(32)) bus ();

    radix4_divider #(.N(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   sa, sbv;
        sa  = a;
        sbv = b;
        if (b == 32'd0) begin
            e.q = 32'hFFFF_FFFF; e.r = a; e.dz = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.q = 32'h8000_0000; e.r = 32'd0; e.dz = 1'b0;
        end else begin
            e.q = sa / sbv; e.r = sa % sbv; e.dz = 1'b0;
        end
        return e;
    endfunction

    task automatic check_zero_outputs(input string tag);
        check({tag, ".busy"}, {31'd0, bus.busy}, 32'd0);
        check({tag, ".done"}, {31'd0, bus.done}, 32'd0);
        check({tag, ".quotient"}, bus.quotient, 32'd0);
        check({tag, ".remainder"}, bus.remainder, 32'd0);
        check({tag, ".dz"}, {31'd0, bus.div_by_zero}, 32'd0);
    endtask

    // ign_k: cycle at which a stray start is pulsed; rst_k: cycle at which reset hits (0 = none).
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int ign_k, input int rst_k);
        int   done_k;
        int   extra_done;
        bit   aborted;
        exp_t e;
        sb.push_back(model(a, b));
        bus.dividend = a;
        bus.divisor  = b;
        bus.start    = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        done_k  = 0;
        aborted = 1'b0;
        for (int k = 1; k <= 40 && done_k == 0 && !aborted; k++) begin
            if (k == ign_k) begin
                bus.start = 1'b1; bus.dividend = 32'd5; bus.divisor = 32'd5;
            end
            if (k == ign_k + 1) bus.start = 1'b0;
            @(posedge clk); #1;
            if (k == rst_k) begin
                rst = 1'b1;
                #1;
                check_zero_outputs("async_reset");
                sb.delete();
                aborted = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
            end else if (bus.done === 1'b1) begin
                done_k = k;
            end else if (k <= 17) begin
                check("busy_during_op", {31'd0, bus.busy}, 32'd1);
            end
        end
        bus.start = 1'b0;
        if (!aborted) begin
            check("done_latency", done_k, 18);
            check("busy_at_done", {31'd0, bus.busy}, 32'd0);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("quotient", bus.quotient, e.q);
                check("remainder", bus.remainder, e.r);
                check("div_by_zero", {31'd0, bus.div_by_zero}, {31'd0, e.dz});
            end else begin
                check("scoreboard_nonempty", 32'd0, 32'd1);
            end
            @(posedge clk); #1;
            check("done_one_cycle", {31'd0, bus.done}, 32'd0);
            check("result_held", bus.quotient, e.q);
        end
        if (ign_k > 0 || rst_k > 0) begin
            extra_done = 0;
            for (int k = 0; k < 25; k++) begin
                @(posedge clk); #1;
                if (bus.done === 1'b1) extra_done++;
            end
            check("no_extra_done", extra_done, 0);
        end
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        #12;
        check_zero_outputs("reset_state");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        run_op(32'd100, 32'd7, 0, 0);
        check("q_100_7_literal", bus.quotient, 32'd14);
        run_op(-32'sd100, 32'd7, 0, 0);
        check("q_m100_7_literal", bus.quotient, 32'hFFFF_FFF2);
        check("r_m100_7_literal", bus.remainder, 32'hFFFF_FFFE);
        run_op(32'd100, -32'sd7, 0, 0);
        run_op(32'd7, 32'd0, 0, 0);
        check("dz_7_0_literal", bus.remainder, 32'd7);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        run_op(32'h7FFF_FFFF, 32'd1, 0, 0);
        run_op(32'd1000, 32'd3, 6, 0);
        check("q_1000_3_literal", bus.quotient, 32'd333);
        check("r_1000_3_literal", bus.remainder, 32'd1);
        run_op(32'd1000, 32'd3, 0, 9);
        run_op(32'd9, 32'd4, 0, 0);
        check("q_9_4_literal", bus.quotient, 32'd2);
        check("r_9_4_literal", bus.remainder, 32'd1);
        run_op(32'h8000_0000, 32'd3, 0, 0);
        run_op(32'd5, 32'd9, 0, 0);
        for (int i = 0; i < 6; i++) begin
            run_op($urandom, $urandom >> $urandom_range(0, 30), 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/radix4_divider.md
Name: radix4_divider

Overview:
- Sequential signed two's-complement integer divider that retires 2 quotient bits per clock (radix-4 restoring).
- It is the inverse-operation companion to the radix-4 Booth multiplier datapath. It shares that block's N-bit operand width and its N/2-iteration cadence.
- Sits beside the multiplier in the arithmetic unit.
- Uses a start/busy/done handshake. Results are held until the next accepted start.

Parameters:
- N, 32, operand width in bits; must be even and ≥ 4.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request a division; sampled only in IDLE
- dividend  input  N  signed dividend; sampled on the accepting edge
- divisor  input  N  signed divisor; sampled on the accepting edge
- busy  output  1  high from the edge after acceptance until done is asserted
- done  output  1  one-cycle pulse; results valid from this cycle on
- quotient  output  N  signed quotient, truncated toward zero
- remainder  output  N  signed remainder; sign follows the dividend
- div_by_zero  output  1  high with results when divisor was 0; held until next accepted start

Behaviour:
- Reset (asynchronous, any state):
  - state=IDLE.
  - busy=0, done=0, quotient=0, remainder=0, div_by_zero=0.
  - Internal registers cleared.
  - A reset mid-operation abandons the operation; no done follows.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - start=1 at an edge: latch the operands.
  - Store the magnitudes |dividend| and |divisor| as N-bit unsigned values.
  - Record sign_q = sign(dividend) XOR sign(divisor) and sign_r = sign(dividend).
  - Clear the partial remainder P (N+2 bits). Load Q with |dividend|.
  - Load the iteration counter with N/2. Go to CALC; busy=1. done drops to 0.
- CALC (exactly N/2 cycles), each cycle:
  - T = {P[N-1:0], Q[N-1:N-2]}, i.e. P shifted left 2 with the top 2 bits of Q appended.
  - Compare T against 3D, 2D and D, computed at N+2 bits (D = |divisor|).
  - Digit q = 3/2/1/0 for the largest multiple that is ≤ T.
  - P ← T − q·D. Q ← {Q[N-3:0], q}.
  - Decrement the counter. After the cycle where it reaches 0, go to FIX.
- FIX (1 cycle):
  - quotient = sign_q ? −Q : Q.
  - remainder = sign_r ? −P[N-1:0] : P[N-1:0].
  - Divisor 0: quotient = all ones, remainder = original dividend, div_by_zero=1.
  - Overflow (dividend = −2^(N−1), divisor = −1): quotient = −2^(N−1), remainder = 0, div_by_zero=0.
  - Go to DONE.
- DONE (1 cycle): done=1, busy=0, then go to IDLE.
- Latency:
  - With the accepting edge as edge 0, done is high after edge N/2+2; with N=32 that is cycles 18..19.
  - Latency is fixed; the special cases are not shortcut.
- start while busy or in DONE is ignored; no queuing. start held high in IDLE is accepted on the first edge.
- Outputs keep their last results in IDLE until the next accepted start; they are not cleared at acceptance.
- Magnitude of −2^(N−1) is 2^(N−1); it is representable as N-bit unsigned.
- All internal arithmetic is at N+2 bits, with no truncation before the compare.

Decomposition:
- Shared package arith_pkg:
  - State enum (IDLE, CALC, FIX, DONE).
  - Localparam CNT_W = $clog2(N/2+1).
  - Digit type (2 bits).
- Sub-module radix4_qsel (combinational):
  - Inputs: T and D.
  - Outputs: digit q and the next partial remainder.
  - Instantiated once inside radix4_divider.

Test Plan:
- 100 / 7 → quotient=14, remainder=2, div_by_zero=0; done high exactly 18 edges after the accepting edge; busy high for edges 1..17.
- −100 / 7 → quotient=−14 (0xFFFFFFF2), remainder=−2 (0xFFFFFFFE); 100 / −7 → quotient=−14, remainder=2.
- 7 / 0 → quotient=0xFFFFFFFF, remainder=7, div_by_zero=1; latency still 18.
- 0x80000000 / 0xFFFFFFFF → quotient=0x80000000, remainder=0; 0x7FFFFFFF / 1 → quotient=0x7FFFFFFF, remainder=0.
- start 1000/3; pulse start with 5/5 at cycle 6 → ignored; results are 333 and 1, and no second done.
- start 1000/3, assert rst at cycle 9 → all outputs 0 immediately (asynchronous) and no done.
  - Then start 9/4 → quotient=2, remainder=1.
